// File: rtl/da_tap_feeder.sv
// Sample FIFO and tap delay line feeding the 4-tap serial DA FIR engine.
// Optional DA_FEED_UNDERRUN_HOLD_EN: on underrun the taps hold instead of shifting in 0.
module da_tap_feeder #(
  parameter int DEPTH        = 4,
  parameter int FRAME_LEN    = 6,
  parameter int UPDATE_PHASE = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [3:0]             x_in0,
  output logic [3:0]             x_in1,
  output logic [3:0]             x_in2,
  output logic [3:0]             x_in3,
  output logic                   frame_sync,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(FRAME_LEN);

  typedef logic [3:0] smp_t;

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   level_q, level_d;
  smp_t          mem_q [DEPTH];
  smp_t          mem_d [DEPTH];
  smp_t          tap_q [4];
  smp_t          tap_d [4];
  logic          underrun_q, underrun_d;
  logic          full, empty, push, upd, pop;

  // Handshake, update strobe and next-state for time base, FIFO and taps.
  always_comb begin
    full        = (level_q == (PW+1)'(DEPTH));
    empty       = (level_q == '0);
    push        = s_valid && !full;
    upd         = (frame_cnt_q == FW'(UPDATE_PHASE));
    pop         = upd && !empty;

    frame_cnt_d = (frame_cnt_q == FW'(FRAME_LEN-1)) ? '0 : frame_cnt_q + 1'b1;

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;

    tap_d      = tap_q;
    underrun_d = underrun_q;
    if (upd) begin
      if (!empty) begin
        tap_d[3] = tap_q[2];
        tap_d[2] = tap_q[1];
        tap_d[1] = tap_q[0];
        tap_d[0] = mem_q[rd_ptr_q];
      end else begin
        underrun_d = 1'b1;
`ifdef DA_FEED_UNDERRUN_HOLD_EN
        tap_d = tap_q;
`else
        tap_d[3] = tap_q[2];
        tap_d[2] = tap_q[1];
        tap_d[1] = tap_q[0];
        tap_d[0] = '0;
`endif
      end
    end
  end

  // State registers; reset discards queued samples and taps at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      underrun_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < 4; i++) tap_q[i] <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      underrun_q  <= underrun_d;
      mem_q       <= mem_d;
      tap_q       <= tap_d;
    end
  end

  assign s_ready    = !full;
  assign frame_sync = (frame_cnt_q == '0);
  assign underrun   = underrun_q;
  assign fifo_level = level_q;
  assign x_in0      = tap_q[0];
  assign x_in1      = tap_q[1];
  assign x_in2      = tap_q[2];
  assign x_in3      = tap_q[3];

endmodule
